// File: rtl/stream_byte_fifo_if.sv
// ============================================================================
//  Module   : stream_byte_fifo_if
//  Brief    : Producer/consumer handshake bundle for stream_byte_fifo.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface stream_byte_fifo_if #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
);
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [AW:0] level;
    logic        overflow;
    logic        clr;

    // Environment side: drives writes, read acceptance and flush.
    modport master (
        output in_data, in_valid, out_ready, clr,
        input  in_ready, out_data, out_valid, level, overflow
    );

    // FIFO side.
    modport slave (
        input  in_data, in_valid, out_ready, clr,
        output in_ready, out_data, out_valid, level, overflow
    );
endinterface

`default_nettype wire

// File: rtl/stream_byte_fifo.sv
// ============================================================================
//  Module   : stream_byte_fifo
//  Brief    : FWFT byte FIFO with sticky overflow flag and synchronous flush.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module stream_byte_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  wire logic            clk,
    input  wire logic            rst,
    stream_byte_fifo_if.slave    bus
);

    logic [7:0]  r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        r_overflow;

    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic        w_drop;

    // Status comes only from registered pointers; no path from in_valid/out_ready.
    assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                     (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);

    // A flush swallows any concurrent push or pop, including drop detection.
    assign w_push = bus.in_valid && !w_full && !bus.clr;
    assign w_drop = bus.in_valid &&  w_full && !bus.clr;
    assign w_pop  = bus.out_ready && !w_empty && !bus.clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else if (bus.clr) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= bus.in_data;
        end
    end

    assign bus.in_ready  = !w_full;
    assign bus.out_valid = !w_empty;
    assign bus.out_data  = w_empty ? 8'h00 : r_mem[r_rd_ptr[AW-1:0]];
    assign bus.level     = r_wr_ptr - r_rd_ptr;
    assign bus.overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_stream_byte_fifo.sv
// ============================================================================
//  Module   : tb_stream_byte_fifo
//  Brief    : Self-checking bench for stream_byte_fifo against a queue model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_stream_byte_fifo;

    localparam int C_DEPTH = 16;
    localparam int C_AW    = 4;

    logic clk;
    logic rst;

    stream_byte_fifo_if #(.DEPTH(C_DEPTH), .AW(C_AW)) bus ();

    stream_byte_fifo #(.DEPTH(C_DEPTH), .AW(C_AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int errors;

    logic [7:0] mq[$];
    logic       m_ovf;

    // Applies one cycle of inputs, advances the reference model across the
    // edge, and returns 1 time unit after the edge with inputs idled.
    task automatic drive_cycle(input logic v, input logic [7:0] d,
                               input logic r, input logic c);
        bit full;
        bit empty;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
        bus.clr       = c;
        full  = (mq.size() == C_DEPTH);
        empty = (mq.size() == 0);
        @(posedge clk);
        if (c) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            if (r && !empty) void'(mq.pop_front());
            if (v && !full)  mq.push_back(d);
            if (v && full)   m_ovf = 1'b1;
        end
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.clr       = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = 8'h00;
        bus.out_ready = 1'b0; bus.clr = 1'b0;
        mq.delete(); m_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 ||
            bus.level !== 5'd0 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset: rdy=%b vld=%b data=%h lvl=%0d ovf=%b, want 1 0 00 0 0",
                     bus.in_ready, bus.out_valid, bus.out_data, bus.level, bus.overflow);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        drive_cycle(1'b1, 8'hA5, 1'b0, 1'b0);
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5 || bus.level !== 5'd1) begin
            errors++;
            $display("FAIL single_push: vld=%b data=%h lvl=%0d, want 1 a5 1",
                     bus.out_valid, bus.out_data, bus.level);
        end
        drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.level !== 5'd0) begin
            errors++;
            $display("FAIL single_pop: vld=%b data=%h lvl=%0d, want 0 00 0",
                     bus.out_valid, bus.out_data, bus.level);
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < C_DEPTH; i++) drive_cycle(1'b1, 8'(i), 1'b0, 1'b0);
        vectors++;
        if (bus.in_ready !== 1'b0 || bus.level !== 5'd16 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL fill: rdy=%b lvl=%0d ovf=%b, want 0 16 0",
                     bus.in_ready, bus.level, bus.overflow);
        end
        drive_cycle(1'b1, 8'hFF, 1'b0, 1'b0);
        vectors++;
        if (bus.overflow !== 1'b1 || bus.level !== 5'd16) begin
            errors++;
            $display("FAIL overflow: ovf=%b lvl=%0d, want 1 16", bus.overflow, bus.level);
        end
        for (int i = 0; i < C_DEPTH; i++) begin
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(i)) begin
                errors++;
                $display("FAIL drain[%0d]: vld=%b data=%h, want 1 %h",
                         i, bus.out_valid, bus.out_data, 8'(i));
            end
            drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        end
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL drained: vld=%b ovf=%b, want 0 1", bus.out_valid, bus.overflow);
        end
    endtask

    task automatic test_full_push_pop();
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < C_DEPTH; i++) drive_cycle(1'b1, 8'(i), 1'b0, 1'b0);
        drive_cycle(1'b1, 8'h55, 1'b1, 1'b0);
        vectors++;
        if (bus.overflow !== 1'b1 || bus.level !== 5'd15 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_push_pop: ovf=%b lvl=%0d rdy=%b, want 1 15 1",
                     bus.overflow, bus.level, bus.in_ready);
        end
        for (int i = 1; i < C_DEPTH; i++) begin
            vectors++;
            if (bus.out_data !== 8'(i)) begin
                errors++;
                $display("FAIL full_push_pop_drain[%0d]: data=%h, want %h",
                         i, bus.out_data, 8'(i));
            end
            drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        end
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_push_pop_tail: vld=%b data=%h, want 0 (55 must be absent)",
                     bus.out_valid, bus.out_data);
        end
    endtask

    task automatic test_wrap_stream();
        logic [7:0] expd;
        bit         bad;
        bad = 1'b0;
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        // Start from a non-zero index so the stream crosses the wrap mid-run.
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, 8'h00, 1'b1, 1'b0);
        drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            if (i > 0) begin
                expd = 8'(8'h30 + i - 1);
                vectors++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== expd) begin
                    errors++;
                    $display("FAIL wrap_data[%0d]: vld=%b data=%h, want 1 %h",
                             i, bus.out_valid, bus.out_data, expd);
                end
            end
            drive_cycle(1'b1, 8'(8'h30 + i), 1'b1, 1'b0);
            if (bus.level > 5'd1) bad = 1'b1;
        end
        vectors++;
        if (bad || bus.level !== 5'd1) begin
            errors++;
            $display("FAIL wrap_level: exceeded=%b final=%0d, want 0 1", bad, bus.level);
        end
    endtask

    task automatic test_clr();
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i <= C_DEPTH; i++) drive_cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        vectors++;
        if (bus.level !== 5'd5 || bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL clr_setup: lvl=%0d ovf=%b, want 5 1", bus.level, bus.overflow);
        end
        drive_cycle(1'b1, 8'h77, 1'b1, 1'b1);
        vectors++;
        if (bus.level !== 5'd0 || bus.overflow !== 1'b0 || bus.out_valid !== 1'b0 ||
            bus.out_data !== 8'h00) begin
            errors++;
            $display("FAIL clr: lvl=%0d ovf=%b vld=%b data=%h, want 0 0 0 00",
                     bus.level, bus.overflow, bus.out_valid, bus.out_data);
        end
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.level !== 5'd0) begin
            errors++;
            $display("FAIL clr_hold: vld=%b lvl=%0d, want 0 0", bus.out_valid, bus.level);
        end
    endtask

    task automatic test_async_reset();
        drive_cycle(1'b1, 8'h11, 1'b0, 1'b0);
        drive_cycle(1'b1, 8'h11, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) drive_cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        mq.delete();
        m_ovf = 1'b0;
        #1;
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 ||
            bus.level !== 5'd0 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: rdy=%b vld=%b data=%h lvl=%0d ovf=%b, want 1 0 00 0 0",
                     bus.in_ready, bus.out_valid, bus.out_data, bus.level, bus.overflow);
        end
        #2;
        rst = 1'b0;
        drive_cycle(1'b1, 8'h3C, 1'b0, 1'b0);
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h3C || bus.level !== 5'd1) begin
            errors++;
            $display("FAIL post_reset_push: vld=%b data=%h lvl=%0d, want 1 3c 1",
                     bus.out_valid, bus.out_data, bus.level);
        end
        drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic       v;
        logic       r;
        logic       c;
        logic [7:0] d;
        logic [7:0] exp_data;
        int         rdy_pct;
        for (int i = 0; i < 400; i++) begin
            case (i / 100)
                0:       rdy_pct = 20;
                1:       rdy_pct = 85;
                2:       rdy_pct = 50;
                default: rdy_pct = 10;
            endcase
            v = ($urandom_range(0, 99) < 70);
            r = ($urandom_range(0, 99) < rdy_pct);
            c = ($urandom_range(0, 63) == 0);
            d = 8'($urandom);
            bus.in_valid = v; bus.in_data = d; bus.out_ready = r; bus.clr = c;
            #1;
            exp_data = (mq.size() != 0) ? mq[0] : 8'h00;
            vectors++;
            if (bus.out_valid !== (mq.size() != 0) || bus.out_data !== exp_data ||
                bus.level !== 5'(mq.size()) || bus.in_ready !== (mq.size() != C_DEPTH) ||
                bus.overflow !== m_ovf) begin
                errors++;
                $display("FAIL random[%0d]: vld=%b data=%h lvl=%0d rdy=%b ovf=%b, want %b %h %0d %b %b",
                         i, bus.out_valid, bus.out_data, bus.level, bus.in_ready, bus.overflow,
                         (mq.size() != 0), exp_data, mq.size(), (mq.size() != C_DEPTH), m_ovf);
            end
            drive_cycle(v, d, r, c);
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        test_reset();
        test_single();
        test_fill_overflow();
        test_full_push_pop();
        test_wrap_stream();
        test_clr();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/stream_byte_fifo.md
# stream_byte_fifo

Synchronous byte FIFO that sits between the UART receiver and the stream-to-Wishbone bridge. The receiver emits single-cycle strobes with no backpressure, and the bridge may stall while a bus cycle is pending. This block absorbs bursts with a valid/ready output side and flags any byte lost to overflow. The same block is reused on the response path, between the bridge's tx stream and the UART transmitter.

## Interface

Parameters:

- `DEPTH`, default 16: number of byte entries; must be a power of 2 and ≥ 2.
- `AW`, auto `$clog2(DEPTH)`: pointer index width.

Ports:

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `in_data`  in  8  write byte.
- `in_valid`  in  1  write request; may be a single-cycle strobe.
- `in_ready`  out  1  high when not full.
- `out_data`  out  8  head byte (first-word-fall-through); 8'h00 whenever `out_valid`=0.
- `out_valid`  out  1  high when not empty.
- `out_ready`  in  1  consumer accepts head byte.
- `level`  out  AW+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky flag: a byte was dropped.
- `clr`  in  1  synchronous flush.

## Operation

- Storage is a DEPTH×8 array, not reset.
- Pointers `wr_ptr` and `rd_ptr` are AW+1 bits each; the MSB is a wrap bit.
- Full: indices equal and wrap bits differ. Empty: pointers equal.
- `level` = `wr_ptr` − `rd_ptr`, modulo 2^(AW+1).
- Push when `in_valid` and not full:
  - write `mem[wr_ptr[AW-1:0]]`;
  - increment `wr_ptr`.
- Drop when `in_valid` and full:
  - the byte is discarded and `overflow` is set to 1;
  - this applies even if a pop happens in the same cycle; full is evaluated on the registered state before the edge.
- Pop when `out_valid` and `out_ready`: increment `rd_ptr`.
- `out_ready` while empty has no effect.
- Simultaneous push and pop, neither full nor empty: both happen and `level` is unchanged.
- Simultaneous push and pop when empty: only the push happens; the pop is ignored because `out_valid`=0.
- Pointer wrap: index bits roll from DEPTH−1 to 0 and the wrap bit toggles. Data order is preserved across wrap.
- `clr`:
  - next edge sets both pointers and `overflow` to 0;
  - has priority over a push or pop in the same cycle; that push is discarded and does not set `overflow`.
- `overflow` clears only on `clr` or `rst`.
- `rst` (asynchronous) returns pointers and `overflow` to 0 immediately. Any in-flight data is lost; memory contents are left unspecified.

## Timing

- Reset values: `in_ready`=1, `out_valid`=0, `out_data`=8'h00, `level`=0, `overflow`=0.
- Write-to-read latency: a byte pushed at edge N gives `out_valid`=1 with that byte on `out_data` after edge N. It is poppable in cycle N+1.
- `out_data` is combinational from the memory read at `rd_ptr`, gated by `out_valid`. It is stable while `out_valid`=1 and `out_ready`=0.
- Following a pop at edge N, the next byte (or `out_valid`=0) appears after edge N.
- `in_ready`, `out_valid`, `level` and `overflow` are derived only from registered state, with no combinational path from `in_valid` or `out_ready`.
- Full throughput: one push and one pop per cycle, sustained indefinitely.
- After a `clr` asserted during cycle N, the outputs show the empty state after edge N.

## Test plan

- **Reset, then single byte:** after reset, push 8'hA5 → next cycle `out_valid`=1, `out_data`=8'hA5, `level`=1. Pop → `out_valid`=0, `out_data`=8'h00, `level`=0.
- **Fill and overflow (DEPTH=16):** push 8'h00..8'h0F → `in_ready`=0, `level`=16. Push 8'hFF → `overflow`=1, `level` stays 16. Drain 16 bytes → order is 8'h00..8'h0F, and 8'hFF never appears.
- **Full plus simultaneous push/pop:** at `level`=16, push 8'h55 and pop in the same cycle → 8'h55 is dropped, `overflow`=1, `level`=15.
- **Wrap-around streaming:** one push and one pop per cycle for 40 bytes of an incrementing pattern → output matches input exactly, and `level` stays ≤1 throughout.
- **clr with a concurrent push:** at `level`=5 with `overflow`=1, assert `clr` together with a push of 8'h77 → next cycle `level`=0, `overflow`=0, `out_valid`=0, and 8'h77 is absent.
- **Asynchronous reset mid-burst:** assert `rst` between clock edges at `level`=7 → outputs return to their reset values before the next edge. After release, a push of 8'h3C reads back as 8'h3C.
